// File: rtl/vga_frame_rd_sched.sv
// Read-side frame scheduler: paces DDR read bursts into the VGA display FIFO.
// Optional feature macro: DOUBLE_BUF_EN (two-bank ping-pong display buffer).
module vga_frame_rd_sched #(
  parameter int ADDR_W      = 28,
  parameter int WORD_BYTES  = 16,
  parameter int FRAME_WORDS = 61440,
  parameter int BURST_LEN   = 64,
  parameter int FIFO_DEPTH  = 512,
  parameter logic [ADDR_W-1:0] BASE0 = ADDR_W'(28'h0000000),
  parameter logic [ADDR_W-1:0] BASE1 = ADDR_W'(28'h0100000)
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [9:0]        fifo_used,
  output logic              fifo_clr,
  input  logic              wr_frame_done,
  input  logic              wr_bank,
  output logic              rd_cmd_en,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [7:0]        rd_cmd_len,
  input  logic              rd_data_valid,
  output logic              rd_bank,
  output logic              frame_active,
  output logic              frame_late
);

  // At least 9 bits so BURST_LEN always fits even for tiny frames.
  localparam int FW_W  = $clog2(FRAME_WORDS + 1);
  localparam int CNT_W = (FW_W > 8) ? FW_W : 9;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_CMD, ST_DATA, ST_DRAIN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   word_off;
  logic [CNT_W-1:0]   words_left;
  logic [7:0]         beat_cnt;
  logic               restart_pend;
  logic               bank_sel;

  logic               beat_done;
  logic               frame_end;
  logic               start_now;
  logic               late_now;
  logic               fifo_ok;
  logic [7:0]         next_len;
  logic [ADDR_W-1:0]  next_addr;

`ifdef DOUBLE_BUF_EN
  logic latest_bank;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      latest_bank <= 1'b0;
    end else if (wr_frame_done) begin
      latest_bank <= wr_bank;
    end
  end

  assign bank_sel = latest_bank;
`else
  logic unused_wr;
  assign unused_wr = wr_frame_done ^ wr_bank;
  assign bank_sel  = 1'b0;
`endif

  always_comb begin
    beat_done = rd_data_valid && (beat_cnt == rd_cmd_len - 8'd1);
    frame_end = (state == ST_DATA) && beat_done && (words_left == CNT_W'(rd_cmd_len));
    fifo_ok   = (32'(fifo_used) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
    next_len  = (words_left < CNT_W'(BURST_LEN)) ? 8'(words_left) : 8'(BURST_LEN);
    next_addr = (rd_bank ? BASE1 : BASE0) + ADDR_W'(word_off) * ADDR_W'(WORD_BYTES);
    start_now = 1'b0;
    late_now  = 1'b0;
    // A frame counts as finished once its last beat has landed (words_left==0 in WAIT).
    case (state)
      ST_IDLE:  start_now = frame_start;
      ST_WAIT: begin
        start_now = frame_start;
        late_now  = frame_start && (words_left != '0);
      end
      ST_CMD:   late_now = frame_start;
      ST_DATA: begin
        start_now = frame_start && beat_done;
        late_now  = frame_start && !frame_end;
      end
      ST_DRAIN: begin
        start_now = beat_done;
        late_now  = frame_start;
      end
      default: begin
        start_now = 1'b0;
        late_now  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      fifo_clr     <= 1'b0;
      rd_cmd_en    <= 1'b0;
      rd_cmd_addr  <= '0;
      rd_cmd_len   <= '0;
      rd_bank      <= 1'b0;
      frame_active <= 1'b0;
      frame_late   <= 1'b0;
      word_off     <= '0;
      words_left   <= '0;
      beat_cnt     <= '0;
      restart_pend <= 1'b0;
    end else begin
      fifo_clr <= 1'b0;
      if (late_now) frame_late <= 1'b1;
      if (start_now) begin
        fifo_clr     <= 1'b1;
        rd_bank      <= bank_sel;
        word_off     <= '0;
        words_left   <= CNT_W'(FRAME_WORDS);
        frame_active <= 1'b1;
        restart_pend <= 1'b0;
        state        <= ST_WAIT;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_WAIT: begin
            if (words_left == '0) begin
              frame_active <= 1'b0;
              state        <= ST_IDLE;
            end else if (fifo_ok) begin
              rd_cmd_len  <= next_len;
              rd_cmd_addr <= next_addr;
              rd_cmd_en   <= 1'b1;
              state       <= ST_CMD;
            end
          end
          // A command is never withdrawn; a late frame_start only redirects its data to DRAIN.
          ST_CMD: begin
            if (frame_start) restart_pend <= 1'b1;
            if (rd_cmd_ready) begin
              rd_cmd_en    <= 1'b0;
              beat_cnt     <= '0;
              restart_pend <= 1'b0;
              state        <= (restart_pend || frame_start) ? ST_DRAIN : ST_DATA;
            end
          end
          ST_DATA: begin
            if (beat_done) begin
              word_off   <= word_off + CNT_W'(rd_cmd_len);
              words_left <= words_left - CNT_W'(rd_cmd_len);
              state      <= ST_WAIT;
            end else begin
              if (rd_data_valid) beat_cnt <= beat_cnt + 8'd1;
              if (frame_start) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (rd_data_valid) beat_cnt <= beat_cnt + 8'd1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_rd_sched.sv
// Bench for vga_frame_rd_sched: full-size instance (index 0) and a 100-word frame instance (index 1).
// Expected read commands are queued when a frame is started and checked as the DUT issues them.
module tb_vga_frame_rd_sched;

  typedef struct {
    logic [27:0] addr;
    logic [7:0]  len;
  } cmd_t;

  logic              vga_clk = 1'b0;
  logic              rst;
  logic [1:0]        frame_start;
  logic [1:0][9:0]   fifo_used;
  logic [1:0]        fifo_clr;
  logic [1:0]        wr_frame_done;
  logic [1:0]        wr_bank;
  logic [1:0]        rd_cmd_en;
  logic [1:0]        rd_cmd_ready;
  logic [1:0][27:0]  rd_cmd_addr;
  logic [1:0][7:0]   rd_cmd_len;
  logic [1:0]        rd_data_valid;
  logic [1:0]        rd_bank;
  logic [1:0]        frame_active;
  logic [1:0]        frame_late;

  cmd_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   len;
  logic exp_bank;
  logic [27:0] exp_base;

  always #5 vga_clk = ~vga_clk;

  vga_frame_rd_sched u_big (
    .vga_clk(vga_clk), .rst(rst), .frame_start(frame_start[0]), .fifo_used(fifo_used[0]),
    .fifo_clr(fifo_clr[0]), .wr_frame_done(wr_frame_done[0]), .wr_bank(wr_bank[0]),
    .rd_cmd_en(rd_cmd_en[0]), .rd_cmd_ready(rd_cmd_ready[0]), .rd_cmd_addr(rd_cmd_addr[0]),
    .rd_cmd_len(rd_cmd_len[0]), .rd_data_valid(rd_data_valid[0]), .rd_bank(rd_bank[0]),
    .frame_active(frame_active[0]), .frame_late(frame_late[0])
  );

  vga_frame_rd_sched #(.FRAME_WORDS(100)) u_small (
    .vga_clk(vga_clk), .rst(rst), .frame_start(frame_start[1]), .fifo_used(fifo_used[1]),
    .fifo_clr(fifo_clr[1]), .wr_frame_done(wr_frame_done[1]), .wr_bank(wr_bank[1]),
    .rd_cmd_en(rd_cmd_en[1]), .rd_cmd_ready(rd_cmd_ready[1]), .rd_cmd_addr(rd_cmd_addr[1]),
    .rd_cmd_len(rd_cmd_len[1]), .rd_data_valid(rd_data_valid[1]), .rd_bank(rd_bank[1]),
    .frame_active(frame_active[1]), .frame_late(frame_late[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse-style inputs are held for one clock edge and then released; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input int d, input logic fs, input logic rdy, input logic dv);
    frame_start[d]   = fs;
    rd_cmd_ready[d]  = rdy;
    rd_data_valid[d] = dv;
    @(posedge vga_clk);
    #1;
    frame_start[d]   = 1'b0;
    rd_cmd_ready[d]  = 1'b0;
    rd_data_valid[d] = 1'b0;
  endtask

  task automatic pushCmd(input logic [27:0] addr, input logic [7:0] l);
    cmd_t e;
    e.addr = addr;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  task automatic waitCmd(input int d, input string tag, output int l);
    cmd_t e;
    int   n = 0;
    while (rd_cmd_en[d] !== 1'b1 && n < 20) begin
      applyStimulus(d, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput({tag, " en"}, 32'(rd_cmd_en[d]), 32'd1);
    l = 0;
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("[TB] FAIL %s sb: observed empty queue, expected a queued command", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({tag, " addr"}, 32'(rd_cmd_addr[d]), 32'(e.addr));
      checkOutput({tag, " len"}, 32'(rd_cmd_len[d]), 32'(e.len));
      l = int'(e.len);
    end
  endtask

  task automatic serveBurst(input int d, input int l);
    applyStimulus(d, 1'b0, 1'b1, 1'b0);
    repeat (l) applyStimulus(d, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    frame_start = '0; wr_frame_done = '0; wr_bank = '0; rd_cmd_ready = '0; rd_data_valid = '0;
    fifo_used = '0;
    @(posedge vga_clk); #1;
    @(posedge vga_clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset fifo_clr", 32'(fifo_clr[d]), 32'd0);
      checkOutput("reset rd_cmd_en", 32'(rd_cmd_en[d]), 32'd0);
      checkOutput("reset rd_cmd_addr", 32'(rd_cmd_addr[d]), 32'd0);
      checkOutput("reset rd_cmd_len", 32'(rd_cmd_len[d]), 32'd0);
      checkOutput("reset rd_bank", 32'(rd_bank[d]), 32'd0);
      checkOutput("reset frame_active", 32'(frame_active[d]), 32'd0);
      checkOutput("reset frame_late", 32'(frame_late[d]), 32'd0);
    end

    // Short frame: 64-beat burst then 36-beat remainder; next frame_start lands on the very last beat.
    pushCmd(28'h0, 8'd64);
    pushCmd(28'h400, 8'd36);
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    checkOutput("small fifo_clr", 32'(fifo_clr[1]), 32'd1);
    checkOutput("small en early", 32'(rd_cmd_en[1]), 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("small en latency", 32'(rd_cmd_en[1]), 32'd1);
    waitCmd(1, "small cmd0", len);
    serveBurst(1, len);
    waitCmd(1, "small cmd1", len);
    applyStimulus(1, 1'b0, 1'b1, 1'b0);
    repeat (35) applyStimulus(1, 1'b0, 1'b0, 1'b1);
    pushCmd(28'h0, 8'd64);
    pushCmd(28'h400, 8'd36);
    applyStimulus(1, 1'b1, 1'b0, 1'b1);
    checkOutput("ontime fifo_clr", 32'(fifo_clr[1]), 32'd1);
    checkOutput("ontime frame_late", 32'(frame_late[1]), 32'd0);
    checkOutput("ontime frame_active", 32'(frame_active[1]), 32'd1);
    waitCmd(1, "small f2 cmd0", len);
    serveBurst(1, len);
    waitCmd(1, "small f2 cmd1", len);
    serveBurst(1, len);
    checkOutput("small active at end", 32'(frame_active[1]), 32'd1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("small active drop", 32'(frame_active[1]), 32'd0);
    checkOutput("small en idle", 32'(rd_cmd_en[1]), 32'd0);
    checkOutput("small late clear", 32'(frame_late[1]), 32'd0);

    // Full-size frame: 960 bursts of 64 beats, each 1024 bytes further on.
    for (int i = 0; i < 960; i++) pushCmd(28'(i * 1024), 8'd64);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput("big fifo_clr", 32'(fifo_clr[0]), 32'd1);
    checkOutput("big active", 32'(frame_active[0]), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("big en latency", 32'(rd_cmd_en[0]), 32'd1);
    for (int i = 0; i < 960; i++) begin
      waitCmd(0, "big cmd", len);
      serveBurst(0, len);
    end
    checkOutput("big active last beat", 32'(frame_active[0]), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("big active drop", 32'(frame_active[0]), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("big no extra cmd", 32'(rd_cmd_en[0]), 32'd0);
    checkOutput("big late clear", 32'(frame_late[0]), 32'd0);

    // FIFO fill threshold: 449+64 > 512 blocks, 448+64 == 512 allows.
    fifo_used[0] = 10'd449;
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput("thr fifo_clr", 32'(fifo_clr[0]), 32'd1);
    repeat (4) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      checkOutput("thr 449 no en", 32'(rd_cmd_en[0]), 32'd0);
    end
    fifo_used[0] = 10'd448;
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("thr 448 en", 32'(rd_cmd_en[0]), 32'd1);
    fifo_used[0] = 10'd0;

    // Back-pressure: command held stable while rd_cmd_ready stays low.
    pushCmd(28'h0, 8'd64);
    waitCmd(0, "hold cmd", len);
    repeat (10) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      checkOutput("hold en", 32'(rd_cmd_en[0]), 32'd1);
      checkOutput("hold addr", 32'(rd_cmd_addr[0]), 32'h0);
      checkOutput("hold len", 32'(rd_cmd_len[0]), 32'd64);
    end

    // Late frame_start on beat 20: remaining 44 beats are drained before the restart.
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    repeat (19) applyStimulus(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    checkOutput("late flag", 32'(frame_late[0]), 32'd1);
    checkOutput("late no clr", 32'(fifo_clr[0]), 32'd0);
    repeat (43) applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain no clr", 32'(fifo_clr[0]), 32'd0);
    checkOutput("drain no en", 32'(rd_cmd_en[0]), 32'd0);
    pushCmd(28'h0, 8'd64);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain done clr", 32'(fifo_clr[0]), 32'd1);
    waitCmd(0, "restart cmd", len);
    checkOutput("late sticky", 32'(frame_late[0]), 32'd1);

    // Writer reports bank 1 mid-frame; only the next frame may switch to it.
`ifdef DOUBLE_BUF_EN
    exp_bank = 1'b1;
    exp_base = 28'h0100000;
`else
    exp_bank = 1'b0;
    exp_base = 28'h0000000;
`endif
    wr_frame_done[0] = 1'b1;
    wr_bank[0] = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    wr_frame_done[0] = 1'b0;
    wr_bank[0] = 1'b0;
    checkOutput("bank mid-frame", 32'(rd_bank[0]), 32'd0);
    checkOutput("bank cmd held", 32'(rd_cmd_en[0]), 32'd1);
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    repeat (62) applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("bank drain no clr", 32'(fifo_clr[0]), 32'd0);
    pushCmd(exp_base, 8'd64);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("bank restart clr", 32'(fifo_clr[0]), 32'd1);
    checkOutput("bank next frame", 32'(rd_bank[0]), 32'(exp_bank));
    waitCmd(0, "bank cmd", len);

    // Reset in the middle of a burst returns everything to idle.
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    repeat (5) applyStimulus(0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rst en", 32'(rd_cmd_en[0]), 32'd0);
    checkOutput("rst active", 32'(frame_active[0]), 32'd0);
    checkOutput("rst late", 32'(frame_late[0]), 32'd0);
    checkOutput("rst bank", 32'(rd_bank[0]), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("idle beats ignored", 32'(rd_cmd_en[0]), 32'd0);
    checkOutput("idle beats no active", 32'(frame_active[0]), 32'd0);
    pushCmd(28'h0, 8'd64);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput("post-rst clr", 32'(fifo_clr[0]), 32'd1);
    waitCmd(0, "post-rst cmd", len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
